// File: rtl/download_router_if.sv
// Download port bundle: HPS ioctl byte stream in, loader write ports and
// session results out.
interface download_router_if;
  logic        dn_download;
  logic        dn_wr;
  logic [24:0] dn_addr;
  logic [7:0]  dn_data;
  logic [7:0]  dn_index;
  logic [16:0] mem_addr;
  logic [7:0]  mem_data;
  logic        bios_wr;
  logic        sprite_wr;
  logic        music_wr;
  logic        busy;
  logic        cpu_hold;
  logic        load_done;
  logic [7:0]  load_index;
  logic [24:0] load_len;
  logic [15:0] load_sum;
  logic        load_ovf;

  modport master (
    output dn_download, dn_wr, dn_addr, dn_data, dn_index,
    input  mem_addr, mem_data, bios_wr, sprite_wr, music_wr, busy, cpu_hold,
           load_done, load_index, load_len, load_sum, load_ovf
  );

  modport slave (
    input  dn_download, dn_wr, dn_addr, dn_data, dn_index,
    output mem_addr, mem_data, bios_wr, sprite_wr, music_wr, busy, cpu_hold,
           load_done, load_index, load_len, load_sum, load_ovf
  );
endinterface

// File: rtl/download_router.sv
// Routes ioctl download bytes to BIOS / sprite / music loaders by file index,
// tracks per-session length, checksum and overflow, and holds the CPU in
// reset while a BIOS image is streaming in.
module download_router #(
  parameter int BIOS_AW    = 14,
  parameter int SPRITE_AW  = 14,
  parameter int MUSIC_AW   = 17,
  parameter int IDX_BIOS   = 0,
  parameter int IDX_SPRITE = 3,
  parameter int IDX_MUSIC  = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  download_router_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t      state, state_n;
  logic        dl_q;
  logic [7:0]  cur_idx;
  logic [24:0] cnt, cnt_n;
  logic [15:0] sum, sum_n;
  logic        ovf, ovf_n;
  logic [2:0]  sel;        // one-hot {music, sprite, bios}; 0 = unmapped index
  logic        in_range;
  logic        accept;
  logic        ovf_hit;
  logic        rise;
  logic        leave;

  assign rise  = bus.dn_download & ~dl_q;
  assign leave = (state == LOAD) & ~bus.dn_download;

  // Target select and range check from the latched index only
  always_comb begin
    sel      = 3'b000;
    in_range = 1'b0;
    if (cur_idx == 8'(IDX_BIOS)) begin
      sel      = 3'b001;
      in_range = (bus.dn_addr >> BIOS_AW) == 25'd0;
    end else if (cur_idx == 8'(IDX_SPRITE)) begin
      sel      = 3'b010;
      in_range = (bus.dn_addr >> SPRITE_AW) == 25'd0;
    end else if (cur_idx == 8'(IDX_MUSIC)) begin
      sel      = 3'b100;
      in_range = (bus.dn_addr >> MUSIC_AW) == 25'd0;
    end
  end

  // Byte acceptance and running session statistics
  always_comb begin
    accept  = (state == LOAD) & bus.dn_wr & (sel != 3'b000) & in_range;
    ovf_hit = (state == LOAD) & bus.dn_wr & (sel != 3'b000) & ~in_range;
    cnt_n   = cnt + {24'd0, accept};
    sum_n   = sum + (accept ? {8'd0, bus.dn_data} : 16'd0);
    ovf_n   = ovf | ovf_hit;
  end

  // Session FSM next state
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (rise) state_n = LOAD;
      LOAD:    if (!bus.dn_download) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Session FSM state register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Edge detect, session counters, registered write port and results.
  // dl_q resets high so a download already running at reset release is skipped.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q           <= 1'b1;
      cur_idx        <= '0;
      cnt            <= '0;
      sum            <= '0;
      ovf            <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_data   <= '0;
      bus.bios_wr    <= 1'b0;
      bus.sprite_wr  <= 1'b0;
      bus.music_wr   <= 1'b0;
      bus.load_done  <= 1'b0;
      bus.load_index <= '0;
      bus.load_len   <= '0;
      bus.load_sum   <= '0;
      bus.load_ovf   <= 1'b0;
    end else begin
      dl_q <= bus.dn_download;
      if (state == IDLE && rise) begin
        cur_idx <= bus.dn_index;
        cnt     <= '0;
        sum     <= '0;
        ovf     <= 1'b0;
      end else if (state == LOAD) begin
        cnt <= cnt_n;
        sum <= sum_n;
        ovf <= ovf_n;
      end
      bus.bios_wr   <= accept & sel[0];
      bus.sprite_wr <= accept & sel[1];
      bus.music_wr  <= accept & sel[2];
      if (accept) begin
        bus.mem_addr <= bus.dn_addr[16:0];
        bus.mem_data <= bus.dn_data;
      end
      // Publish on entry to DONE so results are valid alongside load_done,
      // including a byte that arrives with the falling dn_download.
      bus.load_done <= leave;
      if (leave) begin
        bus.load_index <= cur_idx;
        bus.load_len   <= cnt_n;
        bus.load_sum   <= sum_n;
        bus.load_ovf   <= ovf_n;
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.cpu_hold = (state != IDLE) & (cur_idx == 8'(IDX_BIOS));

endmodule

// File: tb/tb_download_router.sv
// Bench for download_router: directed sessions plus randomized ones, checked
// every cycle against a session-level model of the router.
module tb_download_router;
  logic clk_sys = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk_sys = ~clk_sys;

  download_router_if bus();
  download_router dut (.clk_sys(clk_sys), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Session view: are we in a session, is it the publish cycle, what was latched.
  bit          m_sess, m_pub, m_prev;
  logic [7:0]  m_idx;
  int unsigned m_cnt, m_sum;
  bit          m_ovf;
  bit          e_bios, e_spr, e_mus;
  logic [16:0] e_addr;
  logic [7:0]  e_data;
  logic [7:0]  r_idx;
  int unsigned r_len, r_sum;
  bit          r_ovf;

  int unsigned cap;
  bit          take, miss;
  int unsigned c_n, s_n;
  bit          o_n;

  always_comb begin
    cap  = 0;
    if (m_idx == 8'd0)      cap = 1 << 14;
    else if (m_idx == 8'd3) cap = 1 << 14;
    else if (m_idx == 8'd4) cap = 1 << 17;
    take = m_sess && !m_pub && bus.dn_wr && cap != 0 && bus.dn_addr < cap;
    miss = m_sess && !m_pub && bus.dn_wr && cap != 0 && bus.dn_addr >= cap;
    c_n  = m_cnt + (take ? 1 : 0);
    s_n  = (m_sum + (take ? bus.dn_data : 0)) % 65536;
    o_n  = m_ovf || miss;
  end

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      m_sess <= 0; m_pub <= 0; m_prev <= 1; m_idx <= 0;
      m_cnt <= 0; m_sum <= 0; m_ovf <= 0;
      e_bios <= 0; e_spr <= 0; e_mus <= 0; e_addr <= 0; e_data <= 0;
      r_idx <= 0; r_len <= 0; r_sum <= 0; r_ovf <= 0;
    end else begin
      m_prev <= bus.dn_download;
      e_bios <= take && m_idx == 8'd0;
      e_spr  <= take && m_idx == 8'd3;
      e_mus  <= take && m_idx == 8'd4;
      if (take) begin
        e_addr <= bus.dn_addr[16:0];
        e_data <= bus.dn_data;
      end
      if (!m_sess) begin
        if (bus.dn_download && !m_prev) begin
          m_sess <= 1; m_idx <= bus.dn_index; m_cnt <= 0; m_sum <= 0; m_ovf <= 0;
        end
      end else if (m_pub) begin
        m_pub <= 0; m_sess <= 0;
      end else begin
        m_cnt <= c_n; m_sum <= s_n; m_ovf <= o_n;
        if (!bus.dn_download) begin
          m_pub <= 1;
          r_idx <= m_idx; r_len <= c_n; r_sum <= s_n; r_ovf <= o_n;
        end
      end
    end
  end

  // Every-cycle comparison plus running event totals
  int tot_bios = 0, tot_spr = 0, tot_mus = 0, tot_done = 0, tot_hold = 0;
  always @(negedge clk_sys) begin
    chk("bios_wr",    bus.bios_wr,    e_bios);
    chk("sprite_wr",  bus.sprite_wr,  e_spr);
    chk("music_wr",   bus.music_wr,   e_mus);
    chk("busy",       bus.busy,       m_sess);
    chk("cpu_hold",   bus.cpu_hold,   m_sess && m_idx == 8'd0);
    chk("load_done",  bus.load_done,  m_pub);
    chk("load_index", bus.load_index, r_idx);
    chk("load_len",   bus.load_len,   r_len);
    chk("load_sum",   bus.load_sum,   r_sum);
    chk("load_ovf",   bus.load_ovf,   r_ovf);
    if (bus.bios_wr || bus.sprite_wr || bus.music_wr || !reset_n) begin
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_data", bus.mem_data, e_data);
    end
    tot_bios += int'(bus.bios_wr);
    tot_spr  += int'(bus.sprite_wr);
    tot_mus  += int'(bus.music_wr);
    tot_done += int'(bus.load_done);
    tot_hold += int'(bus.cpu_hold);
  end

  // ---------------- stimulus ----------------
  logic [7:0] fixed_q[$];

  task automatic cyc();
    @(posedge clk_sys); #2;
  endtask

  task automatic session(input logic [7:0] idx, input int n, input int amax,
                         input bit rnd_addr, input bit coinc, input int chg_at,
                         input bit gaps);
    bus.dn_index = idx;
    bus.dn_download = 1'b1;
    cyc();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.dn_wr = 1'b0;
        cyc();
      end
      if (i == chg_at) bus.dn_index = 8'd0;
      bus.dn_wr   = 1'b1;
      bus.dn_addr = rnd_addr ? 25'($urandom_range(0, amax)) : 25'(i);
      bus.dn_data = (i < fixed_q.size()) ? fixed_q[i] : 8'($urandom);
      if (coinc && i == n - 1) bus.dn_download = 1'b0;
      cyc();
    end
    bus.dn_wr = 1'b0;
    bus.dn_download = 1'b0;
    repeat (4) cyc();
    fixed_q.delete();
  endtask

  int b0, s0, mu0, d0, h0;
  task automatic snap();
    b0 = tot_bios; s0 = tot_spr; mu0 = tot_mus; d0 = tot_done; h0 = tot_hold;
  endtask

  initial begin
    bus.dn_download = 0; bus.dn_wr = 0; bus.dn_addr = 0; bus.dn_data = 0; bus.dn_index = 0;
    #1 reset_n = 1'b0;
    repeat (3) cyc();
    chk("rst_len", bus.load_len, 0);
    chk("rst_busy", bus.busy, 0);
    reset_n = 1'b1;
    repeat (2) cyc();

    // BIOS: 01,02,FF at 0..2
    snap();
    fixed_q = '{8'h01, 8'h02, 8'hFF};
    session(8'd0, 3, 0, 0, 0, -1, 0);
    chk("t1_bios_cnt", tot_bios - b0, 3);
    chk("t1_done_cnt", tot_done - d0, 1);
    chk("t1_len", bus.load_len, 3);
    chk("t1_sum", bus.load_sum, 16'h0102);
    chk("t1_ovf", bus.load_ovf, 0);
    chk("t1_hold_cycles", tot_hold - h0, 5);  // LOAD: rise+3 bytes+falling cycle, then DONE

    // Sprite: 16385 bytes, last one out of range
    snap();
    session(8'd3, 16385, 0, 0, 0, -1, 0);
    chk("t2_spr_cnt", tot_spr - s0, 16384);
    chk("t2_len", bus.load_len, 16384);
    chk("t2_ovf", bus.load_ovf, 1);

    // Music with index changing to 0 mid-session
    snap();
    session(8'd4, 20, 0, 0, 0, 5, 1);
    chk("t3_mus_cnt", tot_mus - mu0, 20);
    chk("t3_bios_cnt", tot_bios - b0, 0);
    chk("t3_hold", tot_hold - h0, 0);
    chk("t3_index", bus.load_index, 4);

    // Unmapped index 1
    snap();
    session(8'd1, 10, 0, 0, 0, -1, 0);
    chk("t4_strobes", (tot_bios - b0) + (tot_spr - s0) + (tot_mus - mu0), 0);
    chk("t4_done_cnt", tot_done - d0, 1);
    chk("t4_len", bus.load_len, 0);
    chk("t4_sum", bus.load_sum, 0);
    chk("t4_index", bus.load_index, 1);

    // Write coincident with dn_download falling
    snap();
    fixed_q = '{8'h10, 8'h80};
    session(8'd0, 2, 0, 0, 1, -1, 0);
    chk("t5_bios_cnt", tot_bios - b0, 2);
    chk("t5_len", bus.load_len, 2);
    chk("t5_sum", bus.load_sum, 16'h0090);

    // Reset mid-BIOS-load with dn_download held high
    bus.dn_index = 8'd0; bus.dn_download = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      bus.dn_wr = 1; bus.dn_addr = 25'(i); bus.dn_data = 8'(i + 5); cyc();
    end
    reset_n = 1'b0;
    repeat (3) cyc();
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_len", bus.load_len, 0);
    reset_n = 1'b1;
    snap();
    for (int i = 0; i < 5; i++) begin
      bus.dn_wr = 1; bus.dn_addr = 25'(i); bus.dn_data = 8'h33; cyc();
    end
    chk("t6_no_strobe", tot_bios - b0, 0);
    chk("t6_no_busy", bus.busy, 0);
    bus.dn_wr = 0; bus.dn_download = 0;
    repeat (3) cyc();
    fixed_q = '{8'h07, 8'h09};
    session(8'd0, 2, 0, 0, 0, -1, 0);
    chk("t6_len", bus.load_len, 2);
    chk("t6_sum", bus.load_sum, 16'h0010);

    // Randomized sessions
    for (int k = 0; k < 40; k++) begin
      int sel;
      logic [7:0] ix;
      int amax;
      sel = $urandom_range(0, 4);
      ix = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd3 : (sel == 2) ? 8'd4 :
           (sel == 3) ? 8'd1 : 8'($urandom);
      amax = (ix == 8'd4) ? 140000 : 18000;
      session(ix, $urandom_range(1, 40), amax, 1, $urandom_range(0, 1) == 1,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/download_router.md
Name: download_router

Overview:
- Sits between the HPS ioctl download port and the system core's memory loaders.
- Demultiplexes the byte stream by download index into BIOS, sprite-ROM and music write ports, and issues one registered write strobe per byte.
- Tracks each load session: byte count, 16-bit additive checksum, and an overflow flag.
- Holds the CPU in reset while a BIOS load is in progress.

Parameters:
- BIOS_AW, 14, BIOS address width; BIOS capacity is 2^BIOS_AW bytes.
- SPRITE_AW, 14, sprite ROM address width.
- MUSIC_AW, 17, music RAM address width (YM5/6 data).
- IDX_BIOS, 0, download index routed to BIOS.
- IDX_SPRITE, 3, download index routed to sprite ROM.
- IDX_MUSIC, 4, download index routed to music RAM.

Ports:
- clk_sys  in  1  system clock (24 MHz)
- reset_n  in  1  asynchronous active-low reset
- dn_download  in  1  download session active
- dn_wr  in  1  single-cycle byte-valid strobe
- dn_addr  in  25  byte address within the file
- dn_data  in  8  byte data
- dn_index  in  8  file index
- mem_addr  out  17  registered write address (dn_addr[16:0])
- mem_data  out  8  registered write data
- bios_wr  out  1  BIOS write strobe
- sprite_wr  out  1  sprite ROM write strobe
- music_wr  out  1  music RAM write strobe
- busy  out  1  high in LOAD and DONE
- cpu_hold  out  1  busy AND the latched index equals IDX_BIOS
- load_done  out  1  one-cycle pulse at session end
- load_index  out  8  index of the last completed session
- load_len  out  25  bytes accepted in the last session
- load_sum  out  16  checksum of the last session
- load_ovf  out  1  last session contained at least one out-of-range address

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0 and the state is IDLE.
  - The dn_download edge register resets to 1, so a session already in progress when reset releases is not joined; a fresh rising edge is required.
- States: IDLE, LOAD, DONE.
- IDLE:
  - A rising edge of dn_download (registered previous value is 0, current is 1) moves to LOAD.
  - On that edge: latch dn_index into cur_idx; clear cnt (25 bits), sum (16 bits) and ovf.
  - dn_wr is ignored in IDLE.
- LOAD, for each cycle with dn_wr=1:
  - Target AW is selected from cur_idx. An unmapped index accepts no bytes: no strobe, no count, no checksum update, ovf unchanged.
  - In range (dn_addr < 2^AW): the next cycle drives mem_addr=dn_addr[16:0], mem_data=dn_data, and exactly one strobe high for one cycle. cnt += 1. sum = sum + dn_data, modulo 2^16.
  - Out of range: no strobe, cnt and sum unchanged, ovf set (sticky).
  - Write latency is 1 cycle. Strobes never overlap. mem_addr/mem_data hold their last value when no strobe is active.
- dn_index changes during LOAD are ignored; only the latched cur_idx is used.
- Leaving LOAD:
  - dn_download=0 while in LOAD moves to DONE.
  - A dn_wr coincident with dn_download falling is still processed, and is included in load_len/load_sum.
- DONE (exactly 1 cycle):
  - load_done=1.
  - load_index/load_len/load_sum/load_ovf update from cur_idx/cnt/sum/ovf. Results of an unmapped-index session are also published, with len 0.
  - Next state is IDLE.
- Result registers hold until the next DONE.
- Re-arming: dn_download re-asserting in the DONE cycle is seen as a rising edge only from IDLE. The edge register tracks continuously, so a 1-cycle low gap is enough to start the next session.
- cnt wraps at 2^25 (unreachable in practice). No saturation logic is required.
- cpu_hold is combinational from registered state; it has no glitch paths from dn_* inputs.

Test Plan:
- Reset, then BIOS load (dn_index=0) of bytes 0x01,0x02,0xFF at addr 0..2 → bios_wr pulses 3 times, each 1 cycle after its dn_wr, with mem_addr 0,1,2. Then load_done=1 for 1 cycle, load_len=3, load_sum=0x0102, load_ovf=0. cpu_hold is high from the cycle after the rising edge until IDLE.
- Sprite load (index 3) with 16385 bytes at addr 0..16384 → 16384 sprite_wr pulses, none for addr 16384; load_ovf=1, load_len=16384.
- Music load (index 4) where dn_index changes to 0 mid-session → all strobes remain on music_wr, cpu_hold stays 0, load_index=4.
- Index 1 session of 10 bytes → no strobes, load_done pulses, load_len=0, load_sum=0, load_ovf=0.
- dn_wr in the same cycle dn_download falls (byte 0x80) → strobe issued, byte counted in load_len and load_sum.
- reset_n asserted mid-BIOS-load with dn_download held high, then released → outputs 0 and no strobes until dn_download goes low and high again. A new session then starts with cnt=0.
